// File: rtl/seg_pkg.sv
// Shared constants and types for the eight-digit seven-segment scan driver.
package seg_pkg;

  localparam int unsigned NUM_DIGITS = 8;
  localparam int unsigned SEG_W      = 7;
  localparam int unsigned NIB_W      = 4;
  localparam int unsigned DATA_W     = NIB_W * NUM_DIGITS;

  typedef logic [SEG_W-1:0] seg_t;

  localparam seg_t                  SEG_OFF = 7'h7F;
  localparam logic [NUM_DIGITS-1:0] AN_OFF  = 8'hFF;

  // Active-low {a,b,c,d,e,f,g} patterns for hex digits 0..F.
  localparam seg_t SEG_ROM [16] = '{
    7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
    7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38
  };

endpackage

// File: rtl/hex_seg_rom.sv
// Combinational nibble to active-low segment pattern lookup.
module hex_seg_rom
  import seg_pkg::*;
(
  input  logic [NIB_W-1:0] nib,
  output seg_t             seg_c
);

  assign seg_c = SEG_ROM[nib];

endmodule

// File: rtl/seg_scan_mux.sv
// Eight-digit multiplexed seven-segment scan driver with frame-aligned commit.
// Optional leading-zero blanking is enabled by defining SEG_LZ_BLANK_EN.
module seg_scan_mux
  import seg_pkg::*;
#(
  parameter int unsigned CLK_HZ  = 100_000_000,
  parameter int unsigned STEP_HZ = 8_000,
  parameter int unsigned GUARD   = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [DATA_W-1:0]     in_data,
  output logic                  in_ready,
  output logic [SEG_W-1:0]      C,
  output logic [NUM_DIGITS-1:0] AN,
  output logic                  frame_done
);

  localparam int unsigned DIV   = CLK_HZ / STEP_HZ;
  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned DIG_W = $clog2(NUM_DIGITS);

`ifdef SEG_LZ_BLANK_EN
  localparam logic [NUM_DIGITS-1:0] BLANK_RST = ~NUM_DIGITS'(1);

  // Digit i is blank when nibbles i..top are all zero; digit 0 always shows.
  function automatic logic [NUM_DIGITS-1:0] lz_mask(input logic [DATA_W-1:0] v);
    logic seen;
    lz_mask = '0;
    seen    = 1'b0;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      seen       = seen | (v[NIB_W*i +: NIB_W] != '0);
      lz_mask[i] = ~seen;
    end
  endfunction
`else
  localparam logic [NUM_DIGITS-1:0] BLANK_RST = '0;
`endif

  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DIG_W-1:0]      dig_q, dig_d;
  logic [DATA_W-1:0]     shadow_q, shadow_d;
  logic [DATA_W-1:0]     disp_q, disp_d;
  logic                  pend_q, pend_d;
  logic [NUM_DIGITS-1:0] blank_q, blank_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  seg_t                  c_q, c_d;
  logic                  fd_q, fd_d;

  logic                  tick_c;
  logic                  last_c;
  logic [NIB_W-1:0]      nib_c;
  seg_t                  seg_c;

  assign tick_c = (cnt_q == CNT_W'(DIV - 1));
  assign last_c = tick_c && (dig_q == DIG_W'(NUM_DIGITS - 1));
  assign nib_c  = disp_q[NIB_W*dig_q +: NIB_W];

  hex_seg_rom u_rom (
    .nib   (nib_c),
    .seg_c (seg_c)
  );

  // Slot timing, handshake/commit and registered pin drive.
  always_comb begin
    cnt_d    = tick_c ? '0 : cnt_q + CNT_W'(1);
    dig_d    = tick_c ? dig_q + DIG_W'(1) : dig_q;
    shadow_d = shadow_q;
    disp_d   = disp_q;
    pend_d   = pend_q;
    fd_d     = last_c;
    an_d     = AN_OFF;
    c_d      = SEG_OFF;

    if (in_valid && !pend_q) begin
      shadow_d = in_data;
      pend_d   = 1'b1;
    end
    // Commit only at the frame boundary so a displayed frame never tears.
    if (last_c && pend_q) begin
      disp_d = shadow_q;
      pend_d = 1'b0;
    end

    if (cnt_q >= CNT_W'(GUARD)) begin
      an_d = ~(NUM_DIGITS'(1) << dig_q);
      c_d  = blank_q[dig_q] ? SEG_OFF : seg_c;
    end

`ifdef SEG_LZ_BLANK_EN
    blank_d = lz_mask(disp_d);
`else
    blank_d = '0;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      dig_q    <= '0;
      shadow_q <= '0;
      disp_q   <= '0;
      pend_q   <= 1'b0;
      blank_q  <= BLANK_RST;
      an_q     <= AN_OFF;
      c_q      <= SEG_OFF;
      fd_q     <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      dig_q    <= dig_d;
      shadow_q <= shadow_d;
      disp_q   <= disp_d;
      pend_q   <= pend_d;
      blank_q  <= blank_d;
      an_q     <= an_d;
      c_q      <= c_d;
      fd_q     <= fd_d;
    end
  end

  assign in_ready   = ~pend_q;
  assign AN         = an_q;
  assign C          = c_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_seg_scan_mux.sv
// Scoreboard bench for seg_scan_mux with DIV = 4, GUARD = 1 (32-cycle frames).
module tb_seg_scan_mux;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_ready;
  logic [6:0]  c;
  logic [7:0]  an;
  logic        frame_done;

  always #5 clk = ~clk;

  seg_scan_mux #(
    .CLK_HZ  (8),
    .STEP_HZ (2),
    .GUARD   (1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .C          (c),
    .AN         (an),
    .frame_done (frame_done)
  );

`ifdef SEG_LZ_BLANK_EN
  localparam logic [6:0] Z = 7'h7F;
`else
  localparam logic [6:0] Z = 7'h01;
`endif
  localparam logic [55:0] CODES_ZERO = {Z, Z, Z, Z, Z, Z, Z, 7'h01};
  localparam logic [55:0] CODES_89AB = {7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38};
  localparam logic [55:0] CODES_ONE  = {Z, Z, Z, Z, Z, Z, Z, 7'h4F};
  localparam logic [55:0] CODES_TWO  = {Z, Z, Z, Z, Z, Z, Z, 7'h12};
  localparam logic [55:0] CODES_A05  = {Z, Z, Z, Z, Z, 7'h08, 7'h01, 7'h24};

  typedef struct {
    int         frame;
    int         dig;
    logic [7:0] an;
    logic [6:0] c;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   fd_count = 0;

  always @(posedge clk) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_frame(input int f, input logic [55:0] codes);
    exp_t e;
    for (int d = 0; d < 8; d++) begin
      e.frame = f;
      e.dig   = d;
      e.an    = ~(8'h01 << d);
      e.c     = codes[7*d +: 7];
      sb.push_back(e);
    end
  endtask

  task automatic wait_k(input int k);
    int n;
    n = 0;
    while (cyc != k && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (cyc != k) begin
      checks++;
      errors++;
      $display("FAIL wait_k: reached cyc %0d, expected %0d", cyc, k);
    end
  endtask

  // Monitor: tracks frames and slots, pops the expected pattern at each slot start.
  initial begin
    int         fc;
    int         s;
    int         last_fd;
    logic [7:0] prev_an;
    exp_t       e;
    fc = 0; s = 0; last_fd = 0; prev_an = 8'hFF;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        fc = 0; s = 0; last_fd = 0; prev_an = 8'hFF;
      end else begin
        if (frame_done) begin
          fd_count++;
          chk("fd_phase", 32'(cyc % 32), 32'd0);
          if (last_fd != 0) chk("fd_period", 32'(cyc - last_fd), 32'd32);
          last_fd = cyc;
          fc++;
          s = 0;
        end
        if (an != 8'hFF && prev_an == 8'hFF) begin
          while (sb.size() > 0 && sb[0].frame < fc) begin
            e = sb.pop_front();
            checks++;
            errors++;
            $display("FAIL slot_missed: frame %0d digit %0d never seen", e.frame, e.dig);
          end
          if (sb.size() > 0 && sb[0].frame == fc && sb[0].dig == s) begin
            e = sb.pop_front();
            chk($sformatf("slot_an f%0d d%0d", fc, s), 32'(an), 32'(e.an));
            chk($sformatf("slot_c f%0d d%0d", fc, s), 32'(c), 32'(e.c));
          end
          s++;
        end
        prev_an = an;
      end
    end
  end

  // Stimulus and timing checks.
  initial begin
    repeat (3) @(negedge clk);
    chk("rst_an", 32'(an), 32'hFF);
    chk("rst_c", 32'(c), 32'h7F);
    chk("rst_fd", 32'(frame_done), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd1);
    push_frame(0, CODES_ZERO);
    rst_n = 1'b1;

    wait_k(1);
    chk("guard0_an", 32'(an), 32'hFF);
    chk("guard0_c", 32'(c), 32'h7F);
    for (int k = 2; k <= 4; k++) begin
      wait_k(k);
      chk("d0_an", 32'(an), 32'hFE);
      chk("d0_c", 32'(c), 32'h01);
    end
    wait_k(5);
    chk("guard1_an", 32'(an), 32'hFF);
    wait_k(6);
    chk("d1_an", 32'(an), 32'hFD);
    chk("d1_c", 32'(c), 32'(Z));

    wait_k(10);
    in_valid = 1'b1;
    in_data  = 32'h89ABCDEF;
    push_frame(1, CODES_89AB);
    wait_k(11);
    chk("ready_after_accept", 32'(in_ready), 32'd0);
    in_valid = 1'b0;
    in_data  = '0;
    wait_k(31);
    chk("ready_pend", 32'(in_ready), 32'd0);
    wait_k(32);
    chk("ready_after_commit", 32'(in_ready), 32'd1);
    chk("fd_at_commit", 32'(frame_done), 32'd1);

    wait_k(40);
    in_valid = 1'b1;
    in_data  = 32'h1;
    push_frame(2, CODES_ONE);
    wait_k(41);
    chk("ready_beat1", 32'(in_ready), 32'd0);
    in_data = 32'h2;
    wait_k(63);
    chk("ready_beat2_blocked", 32'(in_ready), 32'd0);
    wait_k(64);
    chk("ready_commit1", 32'(in_ready), 32'd1);
    push_frame(3, CODES_TWO);
    wait_k(65);
    chk("ready_beat2", 32'(in_ready), 32'd0);
    in_valid = 1'b0;
    in_data  = '0;

    wait_k(132);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    in_valid = 1'b1;
    in_data  = 32'h12345678;
    wait_k(133);
    chk("ready_pend_rst", 32'(in_ready), 32'd0);
    in_valid = 1'b0;
    in_data  = '0;
    wait_k(149);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_an", 32'(an), 32'hFF);
    chk("midrst_c", 32'(c), 32'h7F);
    chk("midrst_fd", 32'(frame_done), 32'd0);
    chk("midrst_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    push_frame(0, CODES_ZERO);
    push_frame(1, CODES_ZERO);
    rst_n = 1'b1;

    wait_k(2);
    chk("rerst_d0_an", 32'(an), 32'hFE);
    chk("rerst_ready", 32'(in_ready), 32'd1);
    wait_k(34);
    push_frame(2, CODES_A05);
    push_frame(3, CODES_A05);
    in_valid = 1'b1;
    in_data  = 32'h00000A05;
    wait_k(35);
    in_valid = 1'b0;
    in_data  = '0;

    wait_k(132);
    chk("sb_final", 32'(sb.size()), 32'd0);
    chk("fd_count", 32'(fd_count), 32'd8);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/seg_scan_mux.md
# seg_scan_mux

Eight-digit time-multiplexed scan driver that sits directly upstream of the seven-segment pins. It accepts a 32-bit hex value through a valid/ready handshake and holds it in a shadow register. At a frame boundary it commits the value to the displayed register. It then cycles one-hot active-low anode enables across all eight digits, sending each digit's nibble through the hex-to-segment decode.

## Interface
- `CLK_HZ`, default 100_000_000: input clock frequency.
- `STEP_HZ`, default 8_000: digit-slot rate, giving a 1 kHz full-frame refresh. `DIV = CLK_HZ/STEP_HZ` must be ≥ 4.
- `GUARD`, default 2: cycles at slot start with all anodes off (anti-ghosting). Must be < `DIV`.
- `clk` in 1: the single clock.
- `rst_n` in 1: reset, synchronous and active-low.
- `in_valid` in 1: `in_data` is offered.
- `in_data` in 32: nibble k is shown on digit k; digit 0 is the rightmost (`AN[0]`).
- `in_ready` out 1: shadow register free.
- `C` out 7: segments, active-low, bit order {a,b,c,d,e,f,g} (`C[0]` = g).
- `AN` out 8: anodes, active-low, at most one bit low.
- `frame_done` out 1: one-cycle pulse when slot 7 ends.

## Operation
- Slot counter `cnt` counts 0..DIV-1. `tick` = (`cnt == DIV-1`). Digit index `dig` advances on `tick`, wrapping 7→0.
- Slot output, registered:
  - While `cnt < GUARD`: `AN = 8'hFF`, `C = 7'h7F`.
  - Otherwise: `AN = ~(1 << dig)` and `C = seg(disp[4*dig +: 4])`.
- Segment codes, 0..F: 01, 4F, 12, 06, 4C, 24, 20, 0F, 00, 04, 08, 60, 31, 42, 30, 38 (hex of 7-bit `C`).
- Handshake:
  - Transfer when `in_valid && in_ready`. `shadow <= in_data`, `pend <= 1`, and `in_ready` drops the next cycle.
  - `in_ready = ~pend`.
- Commit: on `tick && dig == 7` with `pend == 1`, `disp <= shadow` and `pend <= 0`.
  - `in_ready` returns high the cycle after the commit.
  - The new value is first shown in slot 0 of the next frame, so a frame never tears.
- Commit without pending data: `disp` is unchanged.
- `in_valid` while `in_ready == 0` is ignored. The source must hold `in_valid` and `in_data` until the transfer.
- `frame_done` is asserted the cycle after `tick && dig == 7`, whether or not a commit occurred.

## Timing
- Reset values: `cnt = 0`, `dig = 0`, `disp = 0`, `shadow = 0`, `pend = 0`, `in_ready = 1`, `AN = 8'hFF`, `C = 7'h7F`, `frame_done = 0`.
- Outputs lag `cnt`/`dig` by one register stage.
- After `rst_n` rises, `AN[0]` is first low GUARD+1 cycles later.
- Frame length is 8·DIV cycles. Each digit is lit for DIV−GUARD cycles per frame.
- Handshake latency:
  - Accept to `disp` update: at most 8·DIV cycles.
  - Accept to first visible slot: the update cycle + GUARD + 1.
- `rst_n` low mid-frame or mid-handshake: next edge applies all reset values and discards a pending shadow value. Scanning restarts at digit 0.

## Configuration
- `SEG_LZ_BLANK_EN` defined: leading-zero blanking.
  - Digits above the highest nonzero nibble of `disp` output `C = 7'h7F` but keep normal `AN` sequencing.
  - `disp == 0` shows a single "0" on digit 0.
  - The blank mask is computed from `disp` and therefore changes only on commit.
- Macro undefined: all eight digits are always decoded, so zeros display as "0".

## Structure
- Package `seg_pkg`:
  - 16-entry segment code constant array.
  - `NUM_DIGITS = 8`.
  - `SEG_OFF = 7'h7F` and `AN_OFF = 8'hFF` constants.
  - `seg_t` (7-bit) typedef.
- Sub-module `hex_seg_rom`: purely combinational nibble→`seg_t` lookup from the package array, instantiated once on the muxed nibble.
- Top holds the counter, digit index, shadow/pend, disp, blank mask and output registers.

## Test plan
Benches run with `CLK_HZ = 8`, `STEP_HZ = 2` (DIV = 4) and `GUARD = 1`.
- Reset release → `AN = FF` and `C = 7F` for 2 cycles. Then `AN = FE`, `C = 01` (digit "0") for 3 cycles, then `AN = FD`.
- Load `32'h89ABCDEF` mid-frame:
  - `in_ready` low until the cycle after `frame_done`'s slot-7 tick.
  - Next frame shows digits 0..7 with `C` = 38, 30, 42, 31, 60, 08, 04, 00.
- Two back-to-back `in_valid` beats (`32'h1`, then `32'h2`) in one frame → only `32'h1` is accepted. The second transfers after the commit and shows a frame later.
- `rst_n` pulsed low during slot 5 with a pending value → all outputs return to reset values. The pending value is never displayed and `in_ready = 1`.
- `SEG_LZ_BLANK_EN` with `32'h00000A05` → digits 0..2 show 24, 01, 08, and digits 3..7 show `C = 7F`. With `32'h0`, digit 0 = 01 and the rest = 7F.
- `frame_done` period check → one pulse every 32 cycles, always one cycle after slot 7 ends.
